// File: rtl/alu_cmd_sequencer.sv
// Command stage for the 12-bit combinational alu: a FIFO of {a, b, op} feeds operand flops, and the results are registered.
// Latency: a command accepted at edge T into an idle unit gives res_valid after edge T+2, and back-to-back commands give one result every 2 cycles.
// Backpressure: cmd_ready drops when the FIFO is full and res_* hold while res_ready is low. Optional feature: ALU_STICKY_OVF_EN.

module alu #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op_select,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             sign,
    output logic             overflow
);
    // ops: 0 abs(a), 1 -a, 2 and, 3 or, 4 xor, 5 not a, 6 add, 7 sub (cout = no borrow)
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH:0]   ONE_X = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] MIN   = {1'b1, {(WIDTH - 1){1'b0}}};

    logic [WIDTH:0] sum;

    always_comb begin
        sum      = '0;
        out      = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        unique case (op_select)
            3'd0: begin
                out      = a[WIDTH-1] ? (~a + ONE) : a;
                overflow = (a == MIN);
            end
            3'd1: begin
                out      = ~a + ONE;
                overflow = (a == MIN);
            end
            3'd2: out = a & b;
            3'd3: out = a | b;
            3'd4: out = a ^ b;
            3'd5: out = ~a;
            3'd6: begin
                sum      = {1'b0, a} + {1'b0, b};
                out      = sum[WIDTH-1:0];
                cout     = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (out[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                sum      = {1'b0, a} + {1'b0, ~b} + ONE_X;
                out      = sum[WIDTH-1:0];
                cout     = sum[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (out[WIDTH-1] != a[WIDTH-1]);
            end
        endcase
        sign = out[WIDTH-1];
    end
endmodule

module alu_cmd_sequencer #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
    output logic             res_sign,
    output logic             res_ovf,
`ifdef ALU_STICKY_OVF_EN
    output logic             sticky_ovf,
    input  logic             sticky_clr,
`endif
    output logic             busy
);
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    cmd_t                  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count, count_next;
    logic                  ready_q;
    logic                  push, pop, load_res;
    state_t                state, state_next;

    logic [WIDTH-1:0] op_a, op_b, alu_out;
    logic [2:0]       op_sel;
    logic             alu_cout, alu_sign, alu_ovf;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a         (op_a),
        .b         (op_b),
        .op_select (op_sel),
        .out       (alu_out),
        .cout      (alu_cout),
        .sign      (alu_sign),
        .overflow  (alu_ovf)
    );

    assign push      = cmd_valid && ready_q;
    assign cmd_ready = ready_q;
    assign busy      = (count != '0) || (state != IDLE);

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_res   = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                load_res   = 1'b1;
                state_next = HOLD;
            end
            default: begin
                // Only the entries present before this edge count, so a same-cycle push waits for IDLE.
                if (res_ready) begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ready_q   <= 1'b0;
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cout  <= 1'b0;
            res_sign  <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            ready_q <= (count_next != FULL);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                op_a   <= mem[rd_ptr].a;
                op_b   <= mem[rd_ptr].b;
                op_sel <= mem[rd_ptr].op;
            end
            if (load_res) begin
                res_valid <= 1'b1;
                res_data  <= alu_out;
                res_cout  <= alu_cout;
                res_sign  <= alu_sign;
                res_ovf   <= alu_ovf;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_STICKY_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     sticky_ovf <= 1'b0;
        else if (load_res && alu_ovf) sticky_ovf <= 1'b1;
        else if (sticky_clr)         sticky_ovf <= 1'b0;
    end
`endif
endmodule
